// File: rtl/rc_column_lsu.sv
// rc_column_lsu: per-column load/store unit. Captures the data requests the
// RCs of one column raise in the same cycle, serialises them onto a single
// OBI-style memory port (lowest row first, one access outstanding), keeps a
// per-row indirect-address register and stalls the column until done.
module rc_column_lsu #(
    parameter int N_ROWS    = 4,
    parameter int DP_WIDTH  = 32,
    parameter int INC_WIDTH = 13
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clr_addr_i,
    input  logic [N_ROWS-1:0]             rc_req_i,
    input  logic [N_ROWS-1:0]             rc_wen_i,
    input  logic [N_ROWS-1:0]             rc_ind_i,
    input  logic [N_ROWS*DP_WIDTH-1:0]    rc_add_i,
    input  logic [N_ROWS*DP_WIDTH-1:0]    rc_wdata_i,
    input  logic [N_ROWS*INC_WIDTH-1:0]   rc_add_inc_i,
    output logic [DP_WIDTH-1:0]           rc_rdata_o,
    output logic [N_ROWS-1:0]             rc_rvalid_o,
    output logic                          col_stall_o,
    output logic                          mem_req_o,
    input  logic                          mem_gnt_i,
    output logic                          mem_we_o,
    output logic [DP_WIDTH-1:0]           mem_addr_o,
    output logic [DP_WIDTH-1:0]           mem_wdata_o,
    input  logic [DP_WIDTH-1:0]           mem_rdata_i,
    input  logic                          mem_rvalid_i
);

    localparam int SEL_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t                                  state_q, state_d;
    logic [N_ROWS-1:0]                       pend_q, pend_d;
    logic [N_ROWS-1:0]                       wen_q, wen_d;
    logic [N_ROWS-1:0]                       ind_q, ind_d;
    logic [N_ROWS-1:0][DP_WIDTH-1:0]         add_q, add_d;
    logic [N_ROWS-1:0][DP_WIDTH-1:0]         wdata_q, wdata_d;
    logic [N_ROWS-1:0][INC_WIDTH-1:0]        inc_q, inc_d;
    logic [N_ROWS-1:0][DP_WIDTH-1:0]         addr_reg_q, addr_reg_d;

    logic [SEL_W-1:0]    sel;
    logic [N_ROWS-1:0]   sel_oh;
    logic                last_pending;
    logic                rvalid_hit;
    logic [DP_WIDTH-1:0] cur_addr;
    logic [DP_WIDTH-1:0] inc_ext;

    // Fixed-priority pick of the lowest pending row; stays valid through RESP
    // because the pending bit is only cleared on the response.
    always_comb begin
        sel = '0;
        for (int i = N_ROWS - 1; i >= 0; i--) begin
            if (pend_q[i]) sel = SEL_W'(i);
        end
    end

    assign sel_oh       = pend_q & ~(pend_q - N_ROWS'(1));
    assign last_pending = ((pend_q & ~sel_oh) == '0);
    assign rvalid_hit   = (state_q == S_RESP) && mem_rvalid_i;
    assign cur_addr     = ind_q[sel] ? addr_reg_q[sel] : add_q[sel];
    assign inc_ext      = {{(DP_WIDTH-INC_WIDTH){inc_q[sel][INC_WIDTH-1]}}, inc_q[sel]};

    // Memory port is driven only while a request is being offered.
    assign mem_req_o   = (state_q == S_REQ);
    assign mem_we_o    = mem_req_o ? wen_q[sel]   : 1'b0;
    assign mem_addr_o  = mem_req_o ? cur_addr     : '0;
    assign mem_wdata_o = mem_req_o ? wdata_q[sel] : '0;

    // Response is forwarded in the cycle it arrives so the RCs can advance
    // at the same edge the stall drops.
    assign rc_rvalid_o = rvalid_hit ? sel_oh : '0;
    assign rc_rdata_o  = rvalid_hit ? mem_rdata_i : '0;
    assign col_stall_o = ((state_q == S_IDLE) && (|rc_req_i)) ||
                         (state_q == S_REQ) ||
                         ((state_q == S_RESP) && !(mem_rvalid_i && last_pending));

    // Next-state: capture in IDLE, issue in REQ, retire in RESP.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        wen_d      = wen_q;
        ind_d      = ind_q;
        add_d      = add_q;
        wdata_d    = wdata_q;
        inc_d      = inc_q;
        addr_reg_d = addr_reg_q;
        case (state_q)
            S_IDLE: begin
                if (|rc_req_i) begin
                    pend_d  = rc_req_i;
                    wen_d   = rc_wen_i;
                    ind_d   = rc_ind_i;
                    add_d   = rc_add_i;
                    wdata_d = rc_wdata_i;
                    inc_d   = rc_add_inc_i;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt_i) begin
                    addr_reg_d[sel] = cur_addr + inc_ext;
                    state_d         = S_RESP;
                end
            end
            S_RESP: begin
                if (mem_rvalid_i) begin
                    pend_d  = pend_q & ~sel_oh;
                    state_d = last_pending ? S_IDLE : S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Kernel start overrides any same-cycle post-increment.
        if (clr_addr_i) addr_reg_d = '0;
    end

    // State and captured request registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            pend_q     <= '0;
            wen_q      <= '0;
            ind_q      <= '0;
            add_q      <= '0;
            wdata_q    <= '0;
            inc_q      <= '0;
            addr_reg_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            wen_q      <= wen_d;
            ind_q      <= ind_d;
            add_q      <= add_d;
            wdata_q    <= wdata_d;
            inc_q      <= inc_d;
            addr_reg_q <= addr_reg_d;
        end
    end

endmodule

// File: tb/tb_rc_column_lsu.sv
// Directed bench for rc_column_lsu: memory side driven by hand, every
// expected value written out in the stimulus.
module tb_rc_column_lsu;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 13;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              clr_addr_i;
    logic [N-1:0]      rc_req_i, rc_wen_i, rc_ind_i;
    logic [N*DW-1:0]   rc_add_i, rc_wdata_i;
    logic [N*IW-1:0]   rc_add_inc_i;
    logic [DW-1:0]     rc_rdata_o;
    logic [N-1:0]      rc_rvalid_o;
    logic              col_stall_o;
    logic              mem_req_o, mem_gnt_i, mem_we_o;
    logic [DW-1:0]     mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic              mem_rvalid_i;

    int n_chk = 0;
    int n_err = 0;

    rc_column_lsu #(.N_ROWS(N), .DP_WIDTH(DW), .INC_WIDTH(IW)) dut (
        .clk_i(clk), .rst_i(rst_i), .clr_addr_i(clr_addr_i),
        .rc_req_i(rc_req_i), .rc_wen_i(rc_wen_i), .rc_ind_i(rc_ind_i),
        .rc_add_i(rc_add_i), .rc_wdata_i(rc_wdata_i), .rc_add_inc_i(rc_add_inc_i),
        .rc_rdata_o(rc_rdata_o), .rc_rvalid_o(rc_rvalid_o), .col_stall_o(col_stall_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change 1 ns after it, checks 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int r, input logic wen, input logic ind,
                           input logic [DW-1:0] add, input logic [DW-1:0] wd,
                           input logic [IW-1:0] inc);
        rc_wen_i[r]              = wen;
        rc_ind_i[r]              = ind;
        rc_add_i[r*DW +: DW]     = add;
        rc_wdata_i[r*DW +: DW]   = wd;
        rc_add_inc_i[r*IW +: IW] = inc;
    endtask

    // One single-row access, immediate grant, response the cycle after.
    task automatic access(input string tag, input int r, input logic wen, input logic ind,
                          input logic [DW-1:0] add, input logic [IW-1:0] inc,
                          input logic [DW-1:0] exp_addr, input logic clr_on_gnt);
        logic [N-1:0] oh;
        oh = N'(1) << r;
        set_row(r, wen, ind, add, 32'h0, inc);
        rc_req_i = oh;
        #1;
        chk({tag, ".cap_stall"}, 32'(col_stall_o), 32'd1);
        tick();
        rc_req_i   = '0;
        mem_gnt_i  = 1'b1;
        clr_addr_i = clr_on_gnt;
        #1;
        chk({tag, ".req"},  32'(mem_req_o), 32'd1);
        chk({tag, ".addr"}, mem_addr_o, exp_addr);
        tick();
        mem_gnt_i    = 1'b0;
        clr_addr_i   = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1234_0000 | 32'(r);
        #1;
        chk({tag, ".rvalid"}, 32'(rc_rvalid_o), 32'(oh));
        chk({tag, ".stall"},  32'(col_stall_o), 32'd0);
        tick();
        mem_rvalid_i = 1'b0;
    endtask

    initial begin
        logic [N-1:0]  rows_oh [3];
        logic [DW-1:0] rows_ad [3];
        logic          rows_we [3];
        rst_i = 1'b1; clr_addr_i = 1'b0;
        rc_req_i = '0; rc_wen_i = '0; rc_ind_i = '0;
        rc_add_i = '0; rc_wdata_i = '0; rc_add_inc_i = '0;
        mem_gnt_i = 1'b0; mem_rdata_i = '0; mem_rvalid_i = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst.req",    32'(mem_req_o),   32'd0);
        chk("rst.stall",  32'(col_stall_o), 32'd0);
        chk("rst.rvalid", 32'(rc_rvalid_o), 32'd0);
        chk("rst.rdata",  rc_rdata_o,       32'd0);
        chk("rst.addr",   mem_addr_o,       32'd0);
        rst_i = 1'b0;
        tick();

        // Single direct load, row 2, one idle RESP cycle before the response
        set_row(2, 1'b0, 1'b0, 32'h100, 32'h0, 13'd0);
        rc_req_i = 4'b0100;
        #1;
        chk("t1.cap_stall", 32'(col_stall_o), 32'd1);
        chk("t1.cap_req",   32'(mem_req_o),   32'd0);
        tick();
        rc_req_i = '0; mem_gnt_i = 1'b1;
        #1;
        chk("t1.req",       32'(mem_req_o),   32'd1);
        chk("t1.addr",      mem_addr_o,       32'h100);
        chk("t1.we",        32'(mem_we_o),    32'd0);
        chk("t1.req_stall", 32'(col_stall_o), 32'd1);
        tick();
        mem_gnt_i = 1'b0;
        #1;
        chk("t1.resp_req",   32'(mem_req_o),   32'd0);
        chk("t1.resp_stall", 32'(col_stall_o), 32'd1);
        chk("t1.resp_rv",    32'(rc_rvalid_o), 32'd0);
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        #1;
        chk("t1.rvalid", 32'(rc_rvalid_o), 32'b0100);
        chk("t1.rdata",  rc_rdata_o,       32'hDEADBEEF);
        chk("t1.stall",  32'(col_stall_o), 32'd0);
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        chk("t1.idle_rv",    32'(rc_rvalid_o), 32'd0);
        chk("t1.idle_stall", 32'(col_stall_o), 32'd0);
        chk("t1.idle_req",   32'(mem_req_o),   32'd0);

        // Rows 0, 1, 3 together; row 1 a store
        set_row(0, 1'b0, 1'b0, 32'h200, 32'h0,  13'd0);
        set_row(1, 1'b1, 1'b0, 32'h204, 32'h55, 13'd0);
        set_row(3, 1'b0, 1'b0, 32'h20C, 32'h0,  13'd0);
        rc_req_i = 4'b1011;
        rows_oh = '{4'b0001, 4'b0010, 4'b1000};
        rows_ad = '{32'h200, 32'h204, 32'h20C};
        rows_we = '{1'b0, 1'b1, 1'b0};
        tick();
        rc_req_i = '0;
        for (int k = 0; k < 3; k++) begin
            mem_gnt_i = 1'b1;
            #1;
            chk($sformatf("t2.req%0d", k),   32'(mem_req_o),   32'd1);
            chk($sformatf("t2.addr%0d", k),  mem_addr_o,       rows_ad[k]);
            chk($sformatf("t2.we%0d", k),    32'(mem_we_o),    32'(rows_we[k]));
            chk($sformatf("t2.rvq%0d", k),   32'(rc_rvalid_o), 32'd0);
            if (rows_we[k]) chk("t2.wdata", mem_wdata_o, 32'h55);
            tick();
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA000 + 32'(k);
            #1;
            chk($sformatf("t2.rv%0d", k),    32'(rc_rvalid_o), 32'(rows_oh[k]));
            chk($sformatf("t2.stall%0d", k), 32'(col_stall_o), (k == 2) ? 32'd0 : 32'd1);
            if (!rows_we[k]) chk($sformatf("t2.rdata%0d", k), rc_rdata_o, 32'hA000 + 32'(k));
            tick();
            mem_rvalid_i = 1'b0;
        end
        #1;
        chk("t2.idle_req", 32'(mem_req_o), 32'd0);
        tick();

        // Indirect stride on row 0 after kernel start
        clr_addr_i = 1'b1;
        tick();
        clr_addr_i = 1'b0;
        access("t3.a", 0, 1'b0, 1'b1, 32'h0, 13'd4,    32'h0, 1'b0);
        access("t3.b", 0, 1'b0, 1'b1, 32'h0, 13'd4,    32'h4, 1'b0);
        access("t3.c", 0, 1'b0, 1'b1, 32'h0, 13'd4,    32'h8, 1'b0);
        access("t3.d", 0, 1'b0, 1'b1, 32'h0, 13'h1FF8, 32'hC, 1'b0);
        access("t3.e", 0, 1'b0, 1'b1, 32'h0, 13'd4,    32'h4, 1'b0);

        // Address wrap-around
        access("t4.dir", 1, 1'b0, 1'b0, 32'hFFFFFFFC, 13'd8, 32'hFFFFFFFC, 1'b0);
        access("t4.ind", 1, 1'b0, 1'b1, 32'h0,        13'd0, 32'h00000004, 1'b0);

        // Grant back-pressure on a store; inputs wiggle and must be ignored
        set_row(2, 1'b1, 1'b0, 32'h300, 32'hA5A5A5A5, 13'd0);
        rc_req_i = 4'b0100;
        tick();
        rc_req_i = '0;
        for (int c = 0; c < 5; c++) begin
            set_row(2, 1'b0, 1'b1, 32'h999 + 32'(c), 32'h0, 13'd1);
            #1;
            chk($sformatf("t5.req%0d", c),   32'(mem_req_o),   32'd1);
            chk($sformatf("t5.addr%0d", c),  mem_addr_o,       32'h300);
            chk($sformatf("t5.we%0d", c),    32'(mem_we_o),    32'd1);
            chk($sformatf("t5.wd%0d", c),    mem_wdata_o,      32'hA5A5A5A5);
            chk($sformatf("t5.stall%0d", c), 32'(col_stall_o), 32'd1);
            tick();
        end
        mem_gnt_i = 1'b1;
        #1;
        chk("t5.gnt_addr", mem_addr_o, 32'h300);
        tick();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        #1;
        chk("t5.rvalid", 32'(rc_rvalid_o), 32'b0100);
        tick();
        mem_rvalid_i = 1'b0;

        // Reset during RESP, then a stale response
        set_row(0, 1'b0, 1'b1, 32'h0, 32'h0, 13'd16);
        rc_req_i = 4'b0001;
        tick();
        rc_req_i = '0; mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0; rst_i = 1'b1;
        tick();
        rst_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD;
        #1;
        chk("t6.rv",    32'(rc_rvalid_o), 32'd0);
        chk("t6.req",   32'(mem_req_o),   32'd0);
        chk("t6.stall", 32'(col_stall_o), 32'd0);
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        chk("t6.rv2", 32'(rc_rvalid_o), 32'd0);
        // Address registers zeroed by reset; clear on grant beats the increment
        access("t6.a", 0, 1'b0, 1'b1, 32'h0, 13'd16, 32'h0,  1'b1);
        access("t6.b", 0, 1'b0, 1'b1, 32'h0, 13'd16, 32'h0,  1'b0);
        access("t6.c", 0, 1'b0, 1'b1, 32'h0, 13'd16, 32'h10, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rc_column_lsu.md
Name: rc_column_lsu

Overview:
- Per-column load/store unit directly downstream of the reconfigurable cells' memory-request outputs.
- Collects the data requests issued by the RCs of one column in the same cycle and serialises them onto a single OBI-style memory port.
- Maintains one indirect-address register per row and returns read data and a valid pulse to each requesting RC.
- Holds the column stalled until every captured request has completed.

Parameters:
- N_ROWS, 4, number of RCs in the column.
- DP_WIDTH, 32, datapath, address and data width.
- INC_WIDTH, 13, width of each RC address increment, signed two's complement.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- clr_addr_i  in  1  kernel start; zeroes all address registers.
- rc_req_i  in  N_ROWS  per-row data request.
- rc_wen_i  in  N_ROWS  per-row write enable (1 = store, 0 = load).
- rc_ind_i  in  N_ROWS  per-row indirect-addressing select.
- rc_add_i  in  N_ROWS*DP_WIDTH  per-row direct address; row r occupies bits [r*DP_WIDTH +: DP_WIDTH].
- rc_wdata_i  in  N_ROWS*DP_WIDTH  per-row store data.
- rc_add_inc_i  in  N_ROWS*INC_WIDTH  per-row post-increment.
- rc_rdata_o  out  DP_WIDTH  load data; shared by all rows, qualified by rc_rvalid_o.
- rc_rvalid_o  out  N_ROWS  one-hot pulse: the access for that row completed.
- col_stall_o  out  1  stall to every RC in the column.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  memory grant.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  DP_WIDTH  byte address.
- mem_wdata_o  out  DP_WIDTH  memory write data.
- mem_rdata_i  in  DP_WIDTH  memory read data.
- mem_rvalid_i  in  1  memory response valid; asserted for both reads and writes.

Behaviour:
- Reset values: state IDLE; pending mask 0; address registers 0; every output 0.
- FSM states:
  - IDLE: if |rc_req_i, latch rc_req_i as the pending mask and capture every row's wen/ind/add/wdata/inc into registers; next state REQ. Otherwise stay in IDLE.
  - REQ: select the lowest-index pending row (fixed priority). Drive mem_req_o=1 with that row's we, addr and wdata. Hold all of them stable until mem_gnt_i. On grant, go to RESP.
  - RESP: mem_req_o=0. On mem_rvalid_i, pulse rc_rvalid_o[row] for one cycle and drive rc_rdata_o=mem_rdata_i (stores: rdata value undefined, pulse still issued). Clear the row's pending bit. Next state is REQ if other bits remain pending, else IDLE.
- Only one transaction is outstanding at a time.
- Minimum latency per access is 2 cycles: grant in the first REQ cycle, rvalid in the cycle after grant.
- Address selection:
  - Direct access (ind=0): mem_addr_o = captured add.
  - Indirect access (ind=1): mem_addr_o = addr_reg[row].
- Address-register update: on grant, addr_reg[row] <= mem_addr_o + sign_extend(inc). The sum wraps modulo 2^DP_WIDTH.
- Stall: col_stall_o = (IDLE & |rc_req_i) | (REQ) | (RESP & ~(mem_rvalid_i & last_pending)).
  - col_stall_o is low in the cycle the final response arrives, so the RCs advance at that edge.
  - The FSM returns to IDLE at that edge, so the same request is never re-captured.
- Inputs are sampled only in IDLE. rc_* changes during REQ or RESP are ignored.
- clr_addr_i zeroes all address registers. If it coincides with a grant update, clr_addr_i wins.
- mem_rvalid_i seen in IDLE or REQ is ignored, including stale responses after reset.
- Reset mid-transaction abandons the access: the pending mask is cleared, no rc_rvalid_o pulse is generated, and mem_req_o drops in the next cycle.
- A single requesting row gives 1 capture cycle plus the access; there is no bubble between consecutive pending rows other than the RESP→REQ transition.

Test Plan:
- Single direct load, row 2: add=0x100, mem_gnt_i immediate, mem_rvalid_i one cycle later with 0xDEADBEEF -> mem_addr_o=0x100; rc_rvalid_o=4'b0100 with rc_rdata_o=0xDEADBEEF; col_stall_o high in the capture, REQ and first RESP cycles, low in the rvalid cycle.
- Rows 0, 1, 3 request together (row1 a store with wdata=0x55) -> mem_req_o issues rows 0, 1, 3 in that order; exactly one rvalid pulse per row; col_stall_o deasserts only on row 3's response.
- Indirect stride, row 0: ind=1, inc=+4 over three kernel iterations after clr_addr_i -> mem_addr_o = 0x0, 0x4, 0x8; then inc=-8 (13-bit) -> next address 0x4.
- Wrap-around: direct add=0xFFFFFFFC, inc=8, then an indirect access -> mem_addr_o=0x00000004.
- Grant back-pressure: mem_gnt_i held low for 5 cycles -> mem_req_o, mem_addr_o, mem_we_o and mem_wdata_o stay stable all 5 cycles; col_stall_o stays high.
- Reset during RESP, followed by a late mem_rvalid_i -> no rc_rvalid_o pulse; FSM in IDLE; address registers 0; a new request afterwards is serviced normally.
